// File: rtl/data_store_buffer_pkg.sv
// Shared types for the data-side store buffer: FSM encoding, access sizes and
// the layout of one buffered store.
package data_store_buffer_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_RD_ADDR = 5'b00010,
        ST_RD_RESP = 5'b00100,
        ST_WR_ADDR = 5'b01000,
        ST_WR_RESP = 5'b10000
    } sb_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } sb_size_e;

    localparam int ENTRY_W = 32 + 2 + 4 + 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sb_entry_t;

    // Word-granular match; size and strobes are deliberately ignored.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return (a[31:2] == b[31:2]);
    endfunction

endpackage

// File: rtl/data_store_buffer_sb_fifo.sv
// Circular store FIFO with a parallel word-address compare across all valid
// entries, so loads can detect conflicts with any buffered or draining store.
module data_store_buffer_sb_fifo
    import data_store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             push_i,
    input  sb_entry_t        push_entry_i,
    input  logic             pop_i,
    output sb_entry_t        head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o,
    input  logic [31:0]      cmp_addr_i,
    output logic             hit_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    sb_entry_t          ent_s [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push_s, do_pop_s;
    logic               hit_s;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign count_o   = count_q;
    assign head_o    = ent_s[head_q];
    assign hit_o     = hit_s;

    // Pointer, occupancy and valid-bit next state.
    always_comb begin
        head_d  = do_pop_s  ? head_q + PTR_W'(1) : head_q;
        tail_d  = do_push_s ? tail_q + PTR_W'(1) : tail_q;
        valid_d = valid_q;
        valid_d[head_q] = do_pop_s  ? 1'b0 : valid_q[head_q];
        valid_d[tail_q] = do_push_s ? 1'b1 : valid_d[tail_q];
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Unpack storage and compare every valid entry against the load word.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_s[i] = sb_entry_t'(mem_q[i]);
            hit_s    = hit_s | (valid_q[i] & same_word(ent_s[i].addr, cmp_addr_i));
        end
    end

    // FIFO state registers; payload written at the tail on push.
    always_ff @(posedge aclk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (do_push_s) begin
                mem_q[tail_q] <= push_entry_i;
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Store buffer between the MEM-stage data port and the AXI converter: stores
// retire into a FIFO and drain in the background, loads bypass unless they hit.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        sb_empty
);

    sb_state_e      state_q, state_d;
    logic           st_ack_q, st_ack_d;
    sb_entry_t      push_entry_s;
    sb_entry_t      head_s;
    logic [PTR_W:0] count_s;
    logic           full_s, empty_s, hit_s;
    logic           in_rd_s, in_wr_s;
    logic           store_acc_s, load_go_s, drain_go_s, pop_s;

    assign push_entry_s = '{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata};

    data_store_buffer_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk         (aclk),
        .reset        (reset),
        .push_i       (store_acc_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .cmp_addr_i   (cpu_addr),
        .hit_o        (hit_s)
    );

    assign in_rd_s = (state_q == ST_RD_ADDR) | (state_q == ST_RD_RESP);
    assign in_wr_s = (state_q == ST_WR_ADDR) | (state_q == ST_WR_RESP);

    // A pending store ack blocks loads so the two data_ok pulses never collide.
    assign store_acc_s = cpu_req & cpu_wr & ~full_s & ~in_rd_s;
    assign load_go_s   = (state_q == ST_IDLE) & cpu_req & ~cpu_wr & ~hit_s & ~st_ack_q;
    assign drain_go_s  = (state_q == ST_IDLE) & ~empty_s & ~load_go_s;
    assign pop_s       = (state_q == ST_WR_RESP) & mem_data_ok;

    assign cpu_addr_ok = store_acc_s | (load_go_s & mem_addr_ok);
    assign cpu_data_ok = st_ack_q | ((state_q == ST_RD_RESP) & mem_data_ok);
    assign cpu_rdata   = mem_rdata;
    assign sb_empty    = (count_s == '0) & ~in_wr_s;

    assign mem_size  = load_go_s ? cpu_size  : head_s.size;
    assign mem_addr  = load_go_s ? cpu_addr  : head_s.addr;
    assign mem_wstrb = load_go_s ? cpu_wstrb : head_s.wstrb;
    assign mem_wdata = load_go_s ? cpu_wdata : head_s.wdata;

    // Next state and downstream request; the head pops only on write completion.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        st_ack_d = store_acc_s;
        case (state_q)
            ST_IDLE: begin
                if (load_go_s) begin
                    mem_req = 1'b1;
                    state_d = mem_addr_ok ? ST_RD_RESP : ST_IDLE;
                end else if (drain_go_s) begin
                    mem_req = 1'b1;
                    mem_wr  = 1'b1;
                    state_d = mem_addr_ok ? ST_WR_RESP : ST_WR_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                state_d = mem_addr_ok ? ST_WR_RESP : ST_WR_ADDR;
            end
            ST_WR_RESP: state_d = mem_data_ok ? ST_IDLE : ST_WR_RESP;
            ST_RD_RESP: state_d = mem_data_ok ? ST_IDLE : ST_RD_RESP;
            // RD_ADDR is never entered; it and any corrupt encoding fall back to IDLE.
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state and store-acknowledge flag.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            st_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_ack_q <= st_ack_d;
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer: a queue-based model checked every cycle
// plus literal expectations for each scenario.
module tb_data_store_buffer;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_addr_ok, cpu_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    data_store_buffer #(.DEPTH(DEPTH)) dut (
        .aclk(aclk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .sb_empty(sb_empty)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } st_t;

    st_t         sbq[$];
    int          m_phase = 0;   // 0 idle, 1 write awaiting accept, 2 write awaiting done, 3 load awaiting done
    bit          m_ack   = 1'b0;
    bit          m_hit, m_full, m_st, m_ld, m_dr, m_req;
    logic [31:0] wlog[$];

    always @(negedge aclk) begin
        if (run) begin
            m_hit = 1'b0;
            foreach (sbq[k]) if (sbq[k].addr[31:2] == cpu_addr[31:2]) m_hit = 1'b1;
            m_full = (sbq.size() >= DEPTH);
            m_st   = cpu_req && cpu_wr && !m_full && (m_phase != 3);
            m_ld   = (m_phase == 0) && cpu_req && !cpu_wr && !m_hit && !m_ack;
            m_dr   = (m_phase == 0) && (sbq.size() > 0) && !m_ld;
            m_req  = m_ld || m_dr || (m_phase == 1);

            chk("cpu_addr_ok", {31'd0, cpu_addr_ok}, {31'd0, m_st || (m_ld && mem_addr_ok)});
            chk("cpu_data_ok", {31'd0, cpu_data_ok}, {31'd0, m_ack || (m_phase == 3 && mem_data_ok)});
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
            chk("sb_empty", {31'd0, sb_empty}, {31'd0, sbq.size() == 0 && m_phase != 1 && m_phase != 2});
            if (m_ld) begin
                chk("ld_mem_wr", {31'd0, mem_wr}, 32'd0);
                chk("ld_mem_addr", mem_addr, cpu_addr);
                chk("ld_mem_size", {30'd0, mem_size}, {30'd0, cpu_size});
            end else if (m_req) begin
                chk("st_mem_wr", {31'd0, mem_wr}, 32'd1);
                chk("st_mem_addr", mem_addr, sbq[0].addr);
                chk("st_mem_size", {30'd0, mem_size}, {30'd0, sbq[0].size});
                chk("st_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, sbq[0].wstrb});
                chk("st_mem_wdata", mem_wdata, sbq[0].wdata);
            end
            if (m_phase == 3 && mem_data_ok) chk("ld_rdata", cpu_rdata, mem_rdata);
            if (mem_req && mem_addr_ok && mem_wr) wlog.push_back(mem_addr);

            if (reset) begin
                sbq.delete();
                m_phase = 0;
                m_ack   = 1'b0;
            end else begin
                case (m_phase)
                    0: begin
                        if (m_ld && mem_addr_ok) m_phase = 3;
                        else if (m_dr)           m_phase = mem_addr_ok ? 2 : 1;
                    end
                    1: if (mem_addr_ok) m_phase = 2;
                    2: if (mem_data_ok) begin void'(sbq.pop_front()); m_phase = 0; end
                    3: if (mem_data_ok) m_phase = 0;
                    default: m_phase = 0;
                endcase
                if (m_st) sbq.push_back('{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata});
                m_ack = m_st;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic store(input logic [31:0] a);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2;
        cpu_addr = a; cpu_wstrb = 4'hF; cpu_wdata = a ^ 32'hA5A5_0000;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = sz;
        cpu_addr = a; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
    endtask

    task automatic serve_one(input logic [31:0] rd);
        int t = 0;
        while (!mem_req && t < 40) begin tick(); t++; end
        chk("serve_timeout", {31'd0, mem_req}, 32'd1);
        if (mem_req) begin
            mem_addr_ok = 1'b1;
            tick();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = rd;
            tick();
            mem_data_ok = 1'b0;
        end
    endtask

    task automatic chk_log(input int base, input logic [31:0] first, input int n);
        chk("log_len", 32'(wlog.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            chk("drain_order", (base + k < wlog.size()) ? wlog[base + k] : 32'hFFFF_FFFF,
                first + 32'(4 * k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = 32'h0;
        cpu_wstrb = 4'h0; cpu_wdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = 32'h0;
        tick();
        run = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge aclk);
        chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_cpu_data_ok", {31'd0, cpu_data_ok}, 32'd0);

        // Single store, memory stalls the address phase.
        tick(); store(32'h0000_1000); cpu_wdata = 32'hDEAD_BEEF;
        @(negedge aclk); chk("t1_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
        chk("t1_no_early_ack", {31'd0, cpu_data_ok}, 32'd0);
        tick(); cpu_req = 1'b0;
        @(negedge aclk); chk("t1_data_ok", {31'd0, cpu_data_ok}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1000);
        chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_mem_wr", {31'd0, mem_wr}, 32'd1);
        tick(); tick();
        @(negedge aclk); chk("t1_held_req", {31'd0, mem_req}, 32'd1);
        chk("t1_held_addr", mem_addr, 32'h0000_1000);
        tick(); mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0;
        @(negedge aclk); chk("t1_resp_req", {31'd0, mem_req}, 32'd0);
        chk("t1_resp_nonempty", {31'd0, sb_empty}, 32'd0);
        tick(); mem_data_ok = 1'b1;
        @(negedge aclk); chk("t1_done_nonempty", {31'd0, sb_empty}, 32'd0);
        tick(); mem_data_ok = 1'b0;
        @(negedge aclk); chk("t1_empty", {31'd0, sb_empty}, 32'd1);

        // Five stores into a four-deep buffer with memory stalled.
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            tick(); store(32'h0000_0100 + 32'(4 * i));
            @(negedge aclk); chk("t2_accept", {31'd0, cpu_addr_ok}, 32'd1);
        end
        tick(); store(32'h0000_0110);
        @(negedge aclk); chk("t2_full_block", {31'd0, cpu_addr_ok}, 32'd0);
        tick(); mem_addr_ok = 1'b1;
        @(negedge aclk); chk("t2_full_block2", {31'd0, cpu_addr_ok}, 32'd0);
        tick(); mem_addr_ok = 1'b0;
        tick(); mem_data_ok = 1'b1;
        @(negedge aclk); chk("t2_no_bypass", {31'd0, cpu_addr_ok}, 32'd0);
        tick(); mem_data_ok = 1'b0;
        @(negedge aclk); chk("t2_accept_after_pop", {31'd0, cpu_addr_ok}, 32'd1);
        tick(); cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) serve_one(32'h0);
        chk_log(base, 32'h0000_0100, 5);

        // Load hitting a buffered store waits for the drain to finish.
        tick(); store(32'h0000_2004);
        tick(); load(32'h0000_2006, 2'd1);
        tick();
        @(negedge aclk); chk("t3_drain_first_wr", {31'd0, mem_wr}, 32'd1);
        chk("t3_drain_first_addr", mem_addr, 32'h0000_2004);
        chk("t3_load_blocked", {31'd0, cpu_addr_ok}, 32'd0);
        tick(); mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0;
        @(negedge aclk); chk("t3_resp_no_req", {31'd0, mem_req}, 32'd0);
        tick(); mem_data_ok = 1'b1;
        @(negedge aclk); chk("t3_still_blocked", {31'd0, cpu_addr_ok}, 32'd0);
        tick(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
        @(negedge aclk); chk("t3_load_wr", {31'd0, mem_wr}, 32'd0);
        chk("t3_load_addr", mem_addr, 32'h0000_2006);
        chk("t3_load_accept", {31'd0, cpu_addr_ok}, 32'd1);
        tick(); cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge aclk); chk("t3_load_data_ok", {31'd0, cpu_data_ok}, 32'd1);
        chk("t3_load_rdata", cpu_rdata, 32'hCAFE_F00D);
        tick(); mem_data_ok = 1'b0;

        // Non-hitting load overtakes a buffered store.
        tick(); store(32'h0000_5000);
        tick(); cpu_req = 1'b0; mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0; store(32'h0000_3000);
        tick(); cpu_req = 1'b0;
        tick(); load(32'h0000_4000, 2'd2); mem_data_ok = 1'b1;
        tick(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
        @(negedge aclk); chk("t4_load_first_wr", {31'd0, mem_wr}, 32'd0);
        chk("t4_load_first_addr", mem_addr, 32'h0000_4000);
        chk("t4_load_accept", {31'd0, cpu_addr_ok}, 32'd1);
        tick(); cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge aclk); chk("t4_no_drain_in_rd", {31'd0, mem_req}, 32'd0);
        chk("t4_rdata", cpu_rdata, 32'h1234_5678);
        tick(); mem_data_ok = 1'b0;
        @(negedge aclk); chk("t4_drain_resumes", mem_addr, 32'h0000_3000);
        chk("t4_drain_wr", {31'd0, mem_wr}, 32'd1);
        serve_one(32'h0);

        // Reset while a write response is outstanding with three entries.
        tick(); store(32'h0000_0600);
        tick(); store(32'h0000_0604);
        tick(); store(32'h0000_0608);
        tick(); cpu_req = 1'b0; mem_addr_ok = 1'b1;
        tick(); mem_addr_ok = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge aclk); chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_sb_empty", {31'd0, sb_empty}, 32'd1);
        tick(); mem_data_ok = 1'b1;
        @(negedge aclk); chk("t5_stray_ignored", {31'd0, sb_empty}, 32'd1);
        chk("t5_stray_no_ack", {31'd0, cpu_data_ok}, 32'd0);
        tick(); mem_data_ok = 1'b0; store(32'h0000_0700);
        tick(); cpu_req = 1'b0;
        serve_one(32'h0);

        // Simultaneous push and pop at two entries, walking pointers past the wrap.
        base = wlog.size();
        tick(); store(32'h0000_0800);
        tick(); store(32'h0000_0804); mem_addr_ok = 1'b1;
        tick(); cpu_req = 1'b0; mem_addr_ok = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick(); store(32'h0000_0808 + 32'(4 * j)); mem_data_ok = 1'b1; mem_addr_ok = 1'b0;
            @(negedge aclk); chk("t6_push_pop_accept", {31'd0, cpu_addr_ok}, 32'd1);
            tick(); cpu_req = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
        end
        tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        tick(); mem_data_ok = 1'b0;
        serve_one(32'h0);
        tick();
        @(negedge aclk); chk("t6_empty", {31'd0, sb_empty}, 32'd1);
        chk_log(base, 32'h0000_0800, 8);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
Store buffer on the CPU data-memory path, between the MEM stage's SRAM-like data port and the data port of the AXI converter.
- Stores are retired into a small FIFO and acknowledged immediately; buffered stores are drained to memory in the background.
- Loads bypass the buffer unless they hit a buffered word. A hit stalls the load until the conflicting store has drained.
- Decouples store latency from the pipeline; at most one memory transaction is outstanding downstream.

Parameters:
DEPTH, 4, number of store entries; power of two, >=2
PTR_W, $clog2(DEPTH), pointer width; derived, never overridden

Ports:
aclk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  request from MEM stage, held until cpu_addr_ok
cpu_wr  in  1  1=store, 0=load
cpu_size  in  2  0=byte, 1=half, 2=word
cpu_addr  in  32  byte address
cpu_wstrb  in  4  byte enables (stores)
cpu_wdata  in  32  store data
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  one-cycle completion pulse, in acceptance order
cpu_rdata  out  32  load data, valid with cpu_data_ok of a load
mem_req  out  1  request to converter data port
mem_wr  out  1  1=drain write, 0=load
mem_size  out  2  size
mem_addr  out  32  address
mem_wstrb  out  4  byte enables
mem_wdata  out  32  write data
mem_addr_ok  in  1  converter accepted request
mem_data_ok  in  1  converter completion
mem_rdata  in  32  converter read data
sb_empty  out  1  no buffered and no in-flight store (used by ibar/dbar/idle)

Behaviour:
Reset: synchronous on aclk, active-high.
- Clears head/tail/count, all entry valid bits, st_ack_q and state (-> IDLE).
- Reset-time outputs: mem_req=0, cpu_addr_ok=0, cpu_data_ok=0, sb_empty=1.
- Reset mid-drain or mid-load discards buffered stores and the in-flight transaction.

Entry fields: addr, size, wstrb, wdata, valid.

Store accept:
- Condition: cpu_req & cpu_wr & count<DEPTH & state not in {RD_ADDR, RD_RESP}.
- Effect: cpu_addr_ok=1 combinationally; entry written at tail on the edge.
- st_ack_q set, giving cpu_data_ok=1 on the next cycle (latency 1).
- When full, no accept; there is no same-cycle bypass from a completing drain.

Load hit:
- hit = any valid entry, or the WR_* in-flight entry, with addr[31:2] == cpu_addr[31:2].
- Size and strobe are ignored (conservative).

Load issue: only in IDLE, with !hit & !st_ack_q.
- mem_req=1, mem_wr=0, mem_* = cpu_* (combinational).
- cpu_addr_ok = mem_addr_ok.
- On accept -> RD_RESP; otherwise stay IDLE (CPU holds request).

Drain: in IDLE, with count>0 and no eligible load (loads have priority).
- Present head entry: mem_req=1, mem_wr=1.
- mem_addr_ok -> WR_RESP; else -> WR_ADDR.
- Head pops (count-1, valid cleared) on mem_data_ok in WR_RESP, not on addr_ok. Hit checks therefore still cover the in-flight entry.

State machine, one-hot: IDLE, WR_ADDR, WR_RESP, RD_RESP (RD_ADDR reserved, unused).
- WR_ADDR: mem_req held with head-entry fields stable; -> WR_RESP on mem_addr_ok.
- WR_RESP: mem_req=0; -> IDLE on mem_data_ok, pop head.
- RD_RESP: mem_req=0; on mem_data_ok -> IDLE, cpu_data_ok=1, cpu_rdata=mem_rdata (same cycle, combinational).
- mem_data_ok in IDLE/WR_ADDR is ignored (protocol error, flagged by assertion).

Simultaneous events:
- Store push and drain pop in the same cycle: count unchanged, both pointers advance.
- Push into a slot freed that cycle is not allowed when full.

Ordering rules:
- cpu_data_ok pulses never overlap: stores blocked while a load is outstanding, loads blocked while st_ack_q=1.
- Pointers wrap modulo DEPTH.

sb_empty = (count==0) & state not in {WR_ADDR, WR_RESP}.

Decomposition:
Shared include (data_sb_defs):
- one-hot state localparams
- SIZE_* encodings
- ENTRY_W = 32+2+4+32

Sub-module sb_fifo (DEPTH entries):
- push/pop, head output, count, full/empty
- parallel word-address compare port returning hit

Top level holds the FSM, the st_ack_q flag and the muxes.

Test Plan:
- Store sw 0x1000=0xDEADBEEF with mem_addr_ok held 0 -> cpu_addr_ok cycle t, cpu_data_ok t+1; mem_req wr=1 addr 0x1000 held stable until addr_ok; sb_empty=0 until mem_data_ok.
- 5 back-to-back stores, DEPTH=4, memory stalled -> 4 accepted, 5th cpu_addr_ok=0 until first drain mem_data_ok, then accepted next cycle; memory sees addresses in issue order.
- Store 0x2004, then load 0x2006 (same word) -> load not presented to mem until store's mem_data_ok; then mem_req wr=0 addr 0x2006, cpu_rdata=mem_rdata.
- Buffer holds 0x3000 and load 0x4000 arrives in IDLE -> load issued before drain; drain resumes after load's mem_data_ok.
- Reset asserted in WR_RESP with 3 entries -> next cycle count=0, mem_req=0, sb_empty=1; later mem_data_ok ignored.
- Push and pop same cycle with count=2 -> count stays 2, tail and head wrap correctly past DEPTH-1.
